// File: rtl/dm_sba_axi_bridge_if.sv
// -----------------------------------------------------------------------------
// dm_sba_axi_bridge_if
// Single-beat AXI4 bundle between the debug-module system-bus bridge and the
// narrow side of the SoC interconnect.
//   AW: awvalid/awready/awaddr/awid/awlen/awsize/awburst/awprot/awcache
//   W : wvalid/wready/wdata/wstrb/wlast
//   B : bvalid/bready/bid/bresp
//   AR: arvalid/arready/araddr/arid/arlen/arsize/arburst/arprot/arcache
//   R : rvalid/rready/rdata/rresp/rlast/rid
// modport master = bridge side, modport slave = interconnect side.
// -----------------------------------------------------------------------------
interface dm_sba_axi_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [ID_WIDTH-1:0]   awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [2:0]            awprot;
    logic [3:0]            awcache;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [ID_WIDTH-1:0]   arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [2:0]            arprot;
    logic [3:0]            arcache;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst, awprot, awcache,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, arprot, arcache,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst, awprot, awcache,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, arprot, arcache,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/dm_sba_axi_bridge.sv
// -----------------------------------------------------------------------------
// dm_sba_axi_bridge
// Turns the debug-module system-bus master port (req/gnt/r_valid) into
// single-beat AXI4 transactions. Exactly one transaction is in flight at a
// time, so replies come back strictly in request order.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_i / gnt_o         request / accepted this cycle (only while idle)
//   addr_i, we_i,
//   wdata_i, be_i         request payload, held by the requester until granted
//   r_valid_o             one-cycle reply pulse for reads and writes
//   r_rdata_o, r_err_o    reply data / bus error, held until the next reply
//   axi                   AXI4 master port (dm_sba_axi_bridge_if.master)
// -----------------------------------------------------------------------------
module dm_sba_axi_bridge #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          ID_WIDTH   = 4,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    r_valid_o,
    output logic [DATA_WIDTH-1:0]   r_rdata_o,
    output logic                    r_err_o,
    dm_sba_axi_bridge_if.master     axi
);
    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] AXI_SIZE   = 3'($clog2(STRB_WIDTH));

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WRITE     = 3'd1;
    localparam logic [2:0] ST_WR_RESP   = 3'd2;
    localparam logic [2:0] ST_READ_ADDR = 3'd3;
    localparam logic [2:0] ST_RD_RESP   = 3'd4;
    localparam logic [2:0] ST_REPLY     = 3'd5;

    logic [2:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0] be_q,      be_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q,  wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q,  w_done_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                  err_q,     err_d;

    logic gnt_s;
    logic aw_hs_s;
    logic w_hs_s;

    // Grant only while idle; reset forces it low even though the state is already IDLE.
    assign gnt_s   = rst_n & req_i & (state_q == ST_IDLE);
    assign aw_hs_s = awvalid_q & axi.awready;
    assign w_hs_s  = wvalid_q & axi.wready;

    // Next-state and datapath for the single-outstanding transaction FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s) begin
                    addr_d    = addr_i;
                    wdata_d   = wdata_i;
                    be_d      = be_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (we_i) begin
                        state_d   = ST_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_READ_ADDR;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // AW and W complete independently, in either order or together.
                if (aw_hs_s) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (w_hs_s) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if ((aw_done_q | aw_hs_s) & (w_done_q | w_hs_s)) begin
                    state_d = ST_WR_RESP;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WR_RESP: begin
                if (axi.bvalid) begin
                    err_d   = axi.bresp[1];
                    rdata_d = '0;
                    state_d = ST_REPLY;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_READ_ADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_RESP;
                end else begin
                    state_d = ST_READ_ADDR;
                end
            end
            ST_RD_RESP: begin
                // SLVERR and DECERR both have bit 1 set; data is forwarded either way.
                if (axi.rvalid) begin
                    err_d   = axi.rresp[1];
                    rdata_d = axi.rdata;
                    state_d = ST_REPLY;
                end else begin
                    state_d = ST_RD_RESP;
                end
            end
            ST_REPLY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign gnt_o     = gnt_s;
    assign r_valid_o = (state_q == ST_REPLY);
    assign r_rdata_o = rdata_q;
    assign r_err_o   = err_q;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awid    = ID_WIDTH'(AXI_ID);
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = AXI_SIZE;
    assign axi.awburst = 2'b01;
    assign axi.awprot  = 3'b000;
    assign axi.awcache = 4'b0010;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = be_q;
    assign axi.wlast   = 1'b1;
    assign axi.bready  = (state_q == ST_WR_RESP);
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arid    = ID_WIDTH'(AXI_ID);
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = AXI_SIZE;
    assign axi.arburst = 2'b01;
    assign axi.arprot  = 3'b000;
    assign axi.arcache = 4'b0010;
    assign axi.rready  = (state_q == ST_RD_RESP);

    // Response IDs and rlast carry no information with a single beat in flight.
    logic unused_s;
    assign unused_s = ^{axi.bid, axi.rid, axi.rlast, axi.bresp[0], axi.rresp[0]};
endmodule

// File: tb/tb_dm_sba_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_dm_sba_axi_bridge
// Directed bench for dm_sba_axi_bridge: a delay-configurable AXI slave,
// a posedge monitor (handshake counters, reply queue, valid hold/drop and
// single-outstanding checks) and directed request sequences.
// -----------------------------------------------------------------------------
module tb_dm_sba_axi_bridge;
    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        r_valid_o;
    logic [31:0] r_rdata_o;
    logic        r_err_o;

    dm_sba_axi_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi_if ();

    dm_sba_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .AXI_ID(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .r_err_o(r_err_o), .axi(axi_if.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // slave configuration
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
    logic [31:0] rd_xor = 32'h0;

    // monitor state
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, rv_cnt = 0, outstanding = 0;
    logic [31:0] last_awaddr, last_araddr, last_wdata;
    logic [3:0]  last_wstrb, last_awid, last_arid, last_awcache, last_arcache;
    logic [2:0]  last_awsize, last_arsize, last_awprot, last_arprot;
    logic [7:0]  last_awlen, last_arlen;
    logic [1:0]  last_awburst, last_arburst;
    logic        last_wlast;
    logic [32:0] rq[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rst_n) break;
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : aw_slave
        axi_if.awready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && axi_if.awvalid) begin
                wait_cycles(aw_dly);
                if (rst_n) begin
                    axi_if.awready = 1'b1;
                    @(negedge clk);
                    axi_if.awready = 1'b0;
                end
            end
        end
    end

    initial begin : w_slave
        axi_if.wready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && axi_if.wvalid) begin
                wait_cycles(w_dly);
                if (rst_n) begin
                    axi_if.wready = 1'b1;
                    @(negedge clk);
                    axi_if.wready = 1'b0;
                end
            end
        end
    end

    initial begin : ar_slave
        axi_if.arready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && axi_if.arvalid) begin
                wait_cycles(ar_dly);
                if (rst_n) begin
                    axi_if.arready = 1'b1;
                    @(negedge clk);
                    axi_if.arready = 1'b0;
                end
            end
        end
    end

    initial begin : b_slave
        axi_if.bvalid = 1'b0;
        axi_if.bresp  = 2'b00;
        axi_if.bid    = 4'h0;
        forever begin
            @(negedge clk);
            if (rst_n && axi_if.bready) begin
                wait_cycles(b_dly);
                if (rst_n && axi_if.bready) begin
                    axi_if.bvalid = 1'b1;
                    axi_if.bresp  = b_resp;
                    axi_if.bid    = 4'h5;
                    @(negedge clk);
                    axi_if.bvalid = 1'b0;
                    axi_if.bresp  = 2'b00;
                end
            end
        end
    end

    initial begin : r_slave
        axi_if.rvalid = 1'b0;
        axi_if.rdata  = 32'h0;
        axi_if.rresp  = 2'b00;
        axi_if.rlast  = 1'b0;
        axi_if.rid    = 4'h0;
        forever begin
            @(negedge clk);
            if (rst_n && axi_if.rready) begin
                wait_cycles(r_dly);
                if (rst_n && axi_if.rready) begin
                    axi_if.rvalid = 1'b1;
                    axi_if.rdata  = last_araddr ^ rd_xor;
                    axi_if.rresp  = r_resp;
                    axi_if.rlast  = 1'b1;
                    axi_if.rid    = 4'h9;
                    @(negedge clk);
                    axi_if.rvalid = 1'b0;
                    axi_if.rdata  = 32'h0;
                    axi_if.rresp  = 2'b00;
                    axi_if.rlast  = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0; p_arv = 1'b0; p_arr = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                outstanding = 0;
                p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0; p_arv = 1'b0; p_arr = 1'b0;
            end else begin
                if (p_awv && p_awr) check_val("aw_drop", axi_if.awvalid, 1'b0);
                else if (p_awv)     check_val("aw_hold", axi_if.awvalid, 1'b1);
                if (p_wv && p_wr)   check_val("w_drop", axi_if.wvalid, 1'b0);
                else if (p_wv)      check_val("w_hold", axi_if.wvalid, 1'b1);
                if (p_arv && p_arr) check_val("ar_drop", axi_if.arvalid, 1'b0);
                else if (p_arv)     check_val("ar_hold", axi_if.arvalid, 1'b1);
                if (gnt_o) begin
                    check_val("one_outstanding", outstanding, 0);
                    outstanding++;
                end
                if (axi_if.awvalid && axi_if.awready) begin
                    aw_cnt++;
                    last_awaddr = axi_if.awaddr;  last_awsize  = axi_if.awsize;
                    last_awlen  = axi_if.awlen;   last_awburst = axi_if.awburst;
                    last_awcache = axi_if.awcache; last_awprot = axi_if.awprot;
                    last_awid   = axi_if.awid;
                end
                if (axi_if.wvalid && axi_if.wready) begin
                    w_cnt++;
                    last_wdata = axi_if.wdata; last_wstrb = axi_if.wstrb; last_wlast = axi_if.wlast;
                end
                if (axi_if.arvalid && axi_if.arready) begin
                    ar_cnt++;
                    last_araddr = axi_if.araddr;  last_arsize  = axi_if.arsize;
                    last_arlen  = axi_if.arlen;   last_arburst = axi_if.arburst;
                    last_arcache = axi_if.arcache; last_arprot = axi_if.arprot;
                    last_arid   = axi_if.arid;
                end
                if (r_valid_o) begin
                    rv_cnt++;
                    outstanding--;
                    rq.push_back({r_err_o, r_rdata_o});
                end
                p_awv = axi_if.awvalid; p_awr = axi_if.awready;
                p_wv  = axi_if.wvalid;  p_wr  = axi_if.wready;
                p_arv = axi_if.arvalid; p_arr = axi_if.arready;
            end
        end
    end

    // Present a request at a negedge and wait (bounded) for its grant.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic keep);
        int n;
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; be_i = b;
        n = 0;
        #1;
        while (!gnt_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("grant_seen", gnt_o, 1'b1);
        @(negedge clk);
        if (!keep) req_i = 1'b0;
    endtask

    task automatic wait_reply(input string tag, input logic exp_err, input logic [31:0] exp_data);
        int n;
        logic [32:0] r;
        n = 0;
        while (rq.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_reply"}, (rq.size() > 0), 1'b1);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            check_val({tag, "_err"},   r[32],   exp_err);
            check_val({tag, "_rdata"}, r[31:0], exp_data);
        end
    endtask

    initial begin : stim
        int aw0, w0, ar0, rv0, n;
        rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; be_i = 4'h0;
        repeat (3) @(negedge clk);
        check_val("rst_gnt",     gnt_o, 1'b0);
        check_val("rst_rvalid",  r_valid_o, 1'b0);
        check_val("rst_rdata",   r_rdata_o, 32'h0);
        check_val("rst_err",     r_err_o, 1'b0);
        check_val("rst_awvalid", axi_if.awvalid, 1'b0);
        check_val("rst_wvalid",  axi_if.wvalid, 1'b0);
        check_val("rst_arvalid", axi_if.arvalid, 1'b0);
        check_val("rst_bready",  axi_if.bready, 1'b0);
        check_val("rst_rready",  axi_if.rready, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: read with 3 wait cycles on R
        r_dly = 3; rd_xor = 32'hDEADBEEF ^ 32'h1000_0000; rv0 = rv_cnt; ar0 = ar_cnt;
        issue(1'b0, 32'h1000_0000, 32'h0, 4'hF, 1'b0);
        wait_reply("t1", 1'b0, 32'hDEADBEEF);
        check_val("t1_araddr",  last_araddr, 32'h1000_0000);
        check_val("t1_arsize",  last_arsize, 3'd2);
        check_val("t1_arlen",   last_arlen, 8'd0);
        check_val("t1_arburst", last_arburst, 2'b01);
        check_val("t1_arcache", last_arcache, 4'b0010);
        check_val("t1_arprot",  last_arprot, 3'b000);
        check_val("t1_arid",    last_arid, 4'h0);
        repeat (3) @(negedge clk);
        check_val("t1_pulses",  rv_cnt - rv0, 1);
        check_val("t1_ar_cnt",  ar_cnt - ar0, 1);
        check_val("t1_hold",    r_rdata_o, 32'hDEADBEEF);

        // 2: write, AW and W accepted together
        r_dly = 0; aw0 = aw_cnt; w0 = w_cnt; rv0 = rv_cnt;
        issue(1'b1, 32'h2000_0004, 32'hA5A5A5A5, 4'b0011, 1'b0);
        wait_reply("t2", 1'b0, 32'h0);
        check_val("t2_awaddr",  last_awaddr, 32'h2000_0004);
        check_val("t2_wdata",   last_wdata, 32'hA5A5A5A5);
        check_val("t2_wstrb",   last_wstrb, 4'b0011);
        check_val("t2_wlast",   last_wlast, 1'b1);
        check_val("t2_awsize",  last_awsize, 3'd2);
        check_val("t2_awlen",   last_awlen, 8'd0);
        check_val("t2_awburst", last_awburst, 2'b01);
        check_val("t2_awcache", last_awcache, 4'b0010);
        check_val("t2_awprot",  last_awprot, 3'b000);
        check_val("t2_awid",    last_awid, 4'h0);
        repeat (2) @(negedge clk);
        check_val("t2_aw_cnt",  aw_cnt - aw0, 1);
        check_val("t2_w_cnt",   w_cnt - w0, 1);
        check_val("t2_pulses",  rv_cnt - rv0, 1);

        // 3: W well before AW, then AW well before W (SLVERR on the second)
        aw_dly = 5; w_dly = 0; aw0 = aw_cnt; w0 = w_cnt; rv0 = rv_cnt;
        issue(1'b1, 32'h3000_0008, 32'h1234_5678, 4'hF, 1'b0);
        wait_reply("t3a", 1'b0, 32'h0);
        aw_dly = 0; w_dly = 5; b_resp = 2'b10;
        issue(1'b1, 32'h3000_000C, 32'h8765_4321, 4'b1100, 1'b0);
        wait_reply("t3b", 1'b1, 32'h0);
        repeat (2) @(negedge clk);
        check_val("t3_aw_cnt", aw_cnt - aw0, 2);
        check_val("t3_w_cnt",  w_cnt - w0, 2);
        check_val("t3_pulses", rv_cnt - rv0, 2);
        check_val("t3_wstrb",  last_wstrb, 4'b1100);
        w_dly = 0; b_resp = 2'b00;

        // 4: DECERR read then OKAY read
        r_resp = 2'b11; rd_xor = 32'h5555_0000;
        issue(1'b0, 32'h4000_0000, 32'h0, 4'hF, 1'b0);
        wait_reply("t4a", 1'b1, 32'h1555_0000);
        r_resp = 2'b00;
        issue(1'b0, 32'h4000_0010, 32'h0, 4'hF, 1'b0);
        wait_reply("t4b", 1'b0, 32'h1555_0010);

        // 5: four back-to-back requests with req_i held high
        rd_xor = 32'h0F0F_0000; rv0 = rv_cnt;
        issue(1'b0, 32'h5000_0000, 32'h0,         4'hF, 1'b1);
        issue(1'b1, 32'h5000_0004, 32'h1111_1111, 4'hF, 1'b1);
        issue(1'b1, 32'h5000_0008, 32'h2222_2222, 4'h1, 1'b1);
        issue(1'b0, 32'h5000_000C, 32'h0,         4'hF, 1'b0);
        wait_reply("t5_0", 1'b0, 32'h5F0F_0000);
        wait_reply("t5_1", 1'b0, 32'h0);
        wait_reply("t5_2", 1'b0, 32'h0);
        wait_reply("t5_3", 1'b0, 32'h5F0F_000C);
        repeat (2) @(negedge clk);
        check_val("t5_pulses", rv_cnt - rv0, 4);
        check_val("t5_wdata",  last_wdata, 32'h2222_2222);

        // 6: reset in RD_RESP, pending write granted afterwards
        r_dly = 20;
        issue(1'b0, 32'h6000_0000, 32'h0, 4'hF, 1'b0);
        n = 0;
        while (!axi_if.rready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_in_rd_resp", axi_if.rready, 1'b1);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h7000_0000; wdata_i = 32'hCAFE_F00D; be_i = 4'hF;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rready",  axi_if.rready, 1'b0);
        check_val("t6_arvalid", axi_if.arvalid, 1'b0);
        check_val("t6_gnt",     gnt_o, 1'b0);
        check_val("t6_rvalid",  r_valid_o, 1'b0);
        check_val("t6_rdata",   r_rdata_o, 32'h0);
        check_val("t6_err",     r_err_o, 1'b0);
        rv0 = rv_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r_dly = 0;
        issue(1'b1, 32'h7000_0000, 32'hCAFE_F00D, 4'hF, 1'b0);
        wait_reply("t6_after", 1'b0, 32'h0);
        repeat (25) @(negedge clk);
        check_val("t6_pulses", rv_cnt - rv0, 1);
        check_val("t6_awaddr", last_awaddr, 32'h7000_0000);
        check_val("leftover_replies", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
